// File: rtl/shift_req_arbiter_pkg.sv
// rtl/shift_req_arbiter_pkg.sv - shared types and constants for the shift request arbiter
// Contents: FSM state encoding, shift direction constants, default widths.
package shift_req_arbiter_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 2;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/four_bit_shifter.sv
// rtl/four_bit_shifter.sv - single-position logical shifter, zero fill
// Ports:
//   in   operand
//   dir  1 = left (<<), 0 = right (>>)
//   out  operand shifted by one position
module four_bit_shifter
    import shift_req_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] in,
    input  logic             dir,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        if (dir == DIR_LEFT) begin
            out = in << 1;
        end else begin
            out = in >> 1;
        end
    end

endmodule

// File: rtl/shift_req_arbiter.sv
// rtl/shift_req_arbiter.sv - two-requester round-robin arbiter feeding a multi-cycle shifter
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/data/dir/cnt  command from requester N (N = 0, 1)
//   reqN_ready               command from requester N accepted this cycle
//   res_valid/data/id        shifted result and owning requester
//   res_ready                consumer accepts the result
//   busy                     operation in progress (state != IDLE)
module shift_req_arbiter
    import shift_req_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_dir,
    input  logic [CNT_W-1:0] req0_cnt,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_dir,
    input  logic [CNT_W-1:0] req1_cnt,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    input  logic             res_ready,
    output logic             busy
);

    state_t           state;
    state_t           next_state;
    logic             ptr;
    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic [CNT_W-1:0] cnt_q;
    logic             id_q;

    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             sel_dir;
    logic [CNT_W-1:0] sel_cnt;
    logic [WIDTH-1:0] shifted;

    four_bit_shifter #(.WIDTH(WIDTH)) u_shifter (
        .in  (data_q),
        .dir (dir_q),
        .out (shifted)
    );

    // The pointer only breaks ties; a lone requester always wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_id = ptr;
        end else begin
            grant_id = req1_valid;
        end
    end

    // Gated with rst so no handshake is reported while reset holds the block.
    assign req0_ready = (state == IDLE) && !rst && req0_valid && (grant_id == 1'b0);
    assign req1_ready = (state == IDLE) && !rst && req1_valid && (grant_id == 1'b1);
    assign accept     = req0_ready || req1_ready;

    assign sel_data = grant_id ? req1_data : req0_data;
    assign sel_dir  = grant_id ? req1_dir  : req0_dir;
    assign sel_cnt  = grant_id ? req1_cnt  : req0_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (sel_cnt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                // Leaving on the last step: cnt_q == 1 decrements to zero this edge.
                if (cnt_q == CNT_W'(1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= 1'b0;
            data_q <= '0;
            dir_q  <= 1'b0;
            cnt_q  <= '0;
            id_q   <= 1'b0;
        end else begin
            if (accept) begin
                data_q <= sel_data;
                dir_q  <= sel_dir;
                cnt_q  <= sel_cnt;
                id_q   <= grant_id;
            end else if (state == SHIFT) begin
                data_q <= shifted;
                cnt_q  <= cnt_q - CNT_W'(1);
            end
            if ((state == DONE) && res_ready) begin
                ptr <= ~id_q;
            end
        end
    end

    always_comb begin
        res_valid = (state == DONE);
        res_data  = res_valid ? data_q : '0;
        res_id    = res_valid && id_q;
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_shift_req_arbiter.sv
// tb/tb_shift_req_arbiter.sv - directed scoreboard bench for shift_req_arbiter
module tb_shift_req_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic [3:0] req0_data;
    logic       req0_dir;
    logic [1:0] req0_cnt;
    logic       req0_ready;
    logic       req1_valid;
    logic [3:0] req1_data;
    logic       req1_dir;
    logic [1:0] req1_cnt;
    logic       req1_ready;
    logic       res_valid;
    logic [3:0] res_data;
    logic       res_id;
    logic       res_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] q_data[$];
    logic       q_id[$];

    shift_req_arbiter #(.WIDTH(4), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_dir   (req0_dir),
        .req0_cnt   (req0_cnt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_dir   (req1_dir),
        .req1_cnt   (req1_cnt),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model_shift(input logic [3:0] d, input logic dir, input int c);
        logic [3:0] r;
        r = d;
        for (int i = 0; i < c; i++) begin
            if (dir) r = {r[2:0], 1'b0};
            else     r = {1'b0, r[3:1]};
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_compare(input string tag);
        logic [3:0] ed;
        logic       ei;
        if (q_data.size() == 0) begin
            check({tag, "_queue_empty"}, 8'd1, 8'd0);
        end else begin
            ed = q_data.pop_front();
            ei = q_id.pop_front();
            check({tag, "_data"}, {4'd0, res_data}, {4'd0, ed});
            check({tag, "_id"}, {7'd0, res_id}, {7'd0, ei});
        end
    endtask

    task automatic wait_res(output int k);
        k = 1;
        @(negedge clk);
        while (!res_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Single request with res_ready high; checks latency, result and return to IDLE.
    task automatic do_req(input string tag, input logic id, input logic [3:0] d,
                          input logic dir, input logic [1:0] c);
        int   k;
        logic rdy;
        @(posedge clk); #1;
        res_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_data = d; req1_dir = dir; req1_cnt = c;
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_dir = dir; req0_cnt = c;
        end
        k = 0;
        @(negedge clk);
        rdy = id ? req1_ready : req0_ready;
        while (!rdy && k < 20) begin
            @(negedge clk);
            k++;
            rdy = id ? req1_ready : req0_ready;
        end
        check({tag, "_accept"}, {7'd0, rdy}, 8'd1);
        check({tag, "_one_ready"}, {7'd0, req0_ready & req1_ready}, 8'd0);
        q_data.push_back(model_shift(d, dir, int'(c)));
        q_id.push_back(id);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({tag, "_ready_pulse"}, {6'd0, req1_ready, req0_ready}, 8'd0);
        wait_res(k);
        check({tag, "_latency"}, 8'(k), 8'(int'(c) + 1));
        check({tag, "_busy_done"}, {7'd0, busy}, 8'd1);
        pop_compare(tag);
        @(posedge clk); #1;
        check({tag, "_idle_valid"}, {7'd0, res_valid}, 8'd0);
        check({tag, "_idle_busy"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        int         k;
        logic [3:0] snap_d;
        logic       snap_i;

        rst        = 1'b1;
        res_ready  = 1'b0;
        req0_valid = 1'b1; req0_data = 4'hF; req0_dir = 1'b1; req0_cnt = 2'd1;
        req1_valid = 1'b1; req1_data = 4'hF; req1_dir = 1'b1; req1_cnt = 2'd1;
        #3;
        check("rst_res_valid", {7'd0, res_valid}, 8'd0);
        check("rst_res_data", {4'd0, res_data}, 8'd0);
        check("rst_res_id", {7'd0, res_id}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_readies", {6'd0, req1_ready, req0_ready}, 8'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        do_req("single", 1'b0, 4'b0011, 1'b1, 2'd2);
        do_req("zero_cnt", 1'b1, 4'b1010, 1'b0, 2'd0);
        do_req("sat_right", 1'b0, 4'b1111, 1'b0, 2'd3);
        do_req("sat_left", 1'b1, 4'b1111, 1'b1, 2'd3);
        do_req("edge_right", 1'b0, 4'b1000, 1'b0, 2'd3);

        // Back-pressure with a competing request held pending.
        @(posedge clk); #1;
        res_ready  = 1'b0;
        req1_valid = 1'b1; req1_data = 4'b0110; req1_dir = 1'b1; req1_cnt = 2'd1;
        k = 0;
        @(negedge clk);
        while (!req1_ready && k < 20) begin @(negedge clk); k++; end
        check("bp_accept", {7'd0, req1_ready}, 8'd1);
        q_data.push_back(model_shift(4'b0110, 1'b1, 1));
        q_id.push_back(1'b1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_data = 4'b1001; req0_dir = 1'b0; req0_cnt = 2'd0;
        wait_res(k);
        check("bp_latency", 8'(k), 8'd2);
        snap_d = res_data;
        snap_i = res_id;
        pop_compare("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {7'd0, res_valid}, 8'd1);
            check("bp_hold_data", {4'd0, res_data}, {4'd0, snap_d});
            check("bp_hold_id", {7'd0, res_id}, {7'd0, snap_i});
            check("bp_req0_ignored", {7'd0, req0_ready}, 8'd0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_no_accept_on_handshake", {7'd0, req0_ready}, 8'd0);
        @(posedge clk); #1;
        check("bp_released", {7'd0, res_valid}, 8'd0);
        check("bp_pending_ready", {7'd0, req0_ready}, 8'd1);
        q_data.push_back(4'b1001);
        q_id.push_back(1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        check("bp_pending_valid", {7'd0, res_valid}, 8'd1);
        pop_compare("bp_pending");
        @(posedge clk); #1;

        // Reset abort during SHIFT, requester still asserting valid.
        req0_valid = 1'b1; req0_data = 4'b0001; req0_dir = 1'b1; req0_cnt = 2'd3;
        @(negedge clk);
        check("abort_accept", {7'd0, req0_ready}, 8'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy_before", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        #1;
        check("abort_res_valid", {7'd0, res_valid}, 8'd0);
        check("abort_res_data", {4'd0, res_data}, 8'd0);
        check("abort_res_id", {7'd0, res_id}, 8'd0);
        check("abort_busy", {7'd0, busy}, 8'd0);
        check("abort_readies", {6'd0, req1_ready, req0_ready}, 8'd0);
        @(posedge clk); #1;
        rst        = 1'b0;
        req0_valid = 1'b0;
        do_req("after_abort", 1'b0, 4'b0001, 1'b1, 2'd3);

        // Contention: both requesters valid continuously, pointer freshly reset.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        res_ready  = 1'b1;
        req0_valid = 1'b1; req0_data = 4'b0101; req0_dir = 1'b1; req0_cnt = 2'd1;
        req1_valid = 1'b1; req1_data = 4'b0110; req1_dir = 1'b0; req1_cnt = 2'd1;
        for (int g = 0; g < 4; g++) begin
            k = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && k < 20) begin
                check("cont_not_both_wait", {7'd0, req0_ready & req1_ready}, 8'd0);
                @(negedge clk);
                k++;
            end
            check("cont_seen", {7'd0, req0_ready | req1_ready}, 8'd1);
            check("cont_not_both", {7'd0, req0_ready & req1_ready}, 8'd0);
            check("cont_grant", {7'd0, req1_ready}, 8'(g % 2));
            if ((g % 2) == 1) q_data.push_back(model_shift(4'b0110, 1'b0, 1));
            else              q_data.push_back(model_shift(4'b0101, 1'b1, 1));
            q_id.push_back(1'((g % 2)));
            @(posedge clk); #1;
            wait_res(k);
            check("cont_latency", 8'(k), 8'd2);
            pop_compare("cont");
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("final_queue_empty", 8'(q_data.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_req_arbiter.md
SHIFT_REQ_ARBITER -- requirements
Module: shift_req_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, 4, data width of operands and results.
- CNT_W, 2, width of the shift-count field.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 has a command pending.
- req0_data  in  WIDTH  requester 0 operand.
- req0_dir  in  1  requester 0 direction: 1 = left (<<), 0 = right (>>).
- req0_cnt  in  CNT_W  requester 0 shift count, 0..3.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req1_valid, req1_data, req1_dir, req1_cnt, req1_ready: same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_data  out  WIDTH  shifted result.
- res_id  out  1  index of the requester that owns the result.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 The block SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-004 In IDLE, when any reqN_valid is high, the block SHALL grant exactly one requester.
- If both are valid, the requester indicated by the round-robin pointer SHALL win.
REQ-005 reqN_ready SHALL be combinational: (state == IDLE) & reqN_valid & granted(N).
- It SHALL be high for at most one requester per cycle.
- A command transfers in the cycle where valid & ready are both high.
REQ-006 On acceptance, the block SHALL latch data, dir, cnt and id into internal registers.
- Next state SHALL be SHIFT if cnt != 0, otherwise DONE.
REQ-007 In SHIFT, each cycle, data SHALL take the one-position logical shift (zero fill) in the latched direction, and cnt SHALL decrement by 1.
- When the decremented cnt reaches 0, next state SHALL be DONE.
REQ-008 In DONE:
- res_valid SHALL be 1.
- res_data and res_id SHALL hold the latched values, stable until the handshake.
REQ-009 On res_valid & res_ready:
- Next state SHALL be IDLE.
- The round-robin pointer SHALL move to the requester that did not own the result.
- No new command SHALL be accepted in that same cycle.
REQ-010 Latency: with acceptance at edge T, res_valid SHALL rise after edge T+1+cnt.
- Zero-count commands SHALL return the unmodified operand 1 cycle after acceptance.
REQ-011 Requester inputs SHALL be ignored outside IDLE.
- A requester holding valid SHALL keep its command pending without loss.
REQ-012 Sustained back-pressure (res_ready low) SHALL hold DONE indefinitely with no output change.
REQ-013 Shifts of WIDTH-1 positions and beyond SHALL never wrap bits (e.g. 4'b1000 >> 3 = 4'b0001; 4'b0001 << 3 = 4'b1000; 4'b1111 >> 3 = 4'b0001).
REQ-014 busy SHALL equal (state != IDLE).

Reset
REQ-015 While rst is high, the following SHALL hold: state = IDLE, pointer = requester 0, res_valid = 0, res_data = 0, res_id = 0, busy = 0, latched cnt/dir = 0, both reqN_ready = 0.
REQ-016 Assertion of rst mid-SHIFT or mid-DONE SHALL abort the operation immediately.
- The in-flight result SHALL be discarded.
- The first command after deassertion SHALL be accepted normally.

Structure
REQ-017 A shared package SHALL hold:
- the FSM state encoding (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2);
- the direction constants DIR_LEFT = 1 and DIR_RIGHT = 0;
- the WIDTH/CNT_W defaults.
REQ-018 The single-step shift SHALL be the existing combinational sub-module four_bit_shifter (in, dir, out), instantiated once.
- The count decrement SHALL be a plain registered subtraction inside this block.

Verification
REQ-019 Single request: req0 {data=4'b0011, dir=1, cnt=2}, res_ready=1 -> req0_ready pulses 1 cycle; res_valid after 3 edges; res_data=4'b1100, res_id=0.
REQ-020 Zero count: req1 {data=4'b1010, dir=0, cnt=0} -> res_valid 1 cycle after acceptance; res_data=4'b1010, res_id=1.
REQ-021 Contention: both valid continuously, all cnt=1 -> grants alternate 0,1,0,1 after reset; no cycle with both readies high.
REQ-022 Back-pressure: res_ready low for 5 cycles in DONE -> res_valid, res_data and res_id constant; req0_valid ignored until the handshake.
REQ-023 Reset abort: rst pulsed during SHIFT of {4'b0001, dir=1, cnt=3} -> all outputs zero immediately; the next request {4'b0001, dir=1, cnt=3} yields 4'b1000.
REQ-024 Saturation: {4'b1111, dir=0, cnt=3} -> 4'b0001; {4'b1111, dir=1, cnt=3} -> 4'b1000.
